// File: rtl/hamming_pkg.sv
// Shared types and helpers for the parametrised serial Hamming encoder.
//
// Contents:
//   state_e     - encoder FSM states (IDLE / LOAD / EMIT)
//   MAX_R       - largest supported number of parity bits
//   pos_of      - codeword position (1-based) of data bit j
//   parity_mask - set of parity indices a codeword position feeds
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam int MAX_R = 6;

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int pos_of(input int j);
    int seen;
    int result;
    seen   = 0;
    result = 0;
    for (int pos = 1; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (seen == j && result == 0) result = pos;
        seen++;
      end
    end
    return result;
  endfunction

  // Parity p_i covers every position whose binary index has bit i set.
  function automatic logic [MAX_R-1:0] parity_mask(input int pos, input int r);
    logic [MAX_R-1:0] m;
    for (int i = 0; i < MAX_R; i++) begin
      m[i] = (i < r) && pos[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_serial_enc.sv
// Parametrised serial Hamming encoder.
//
// Collects K = 2^R-1-R data bits LSB-first over a valid/ready stream, then
// emits the codeword serially: data bits d0..d(K-1), then parity p0..p(R-1).
// Parity is accumulated while the word loads, so emission starts the cycle
// after the last input bit is accepted.
//
// Optional feature: define HAMMING_SECDED_EN to append an overall-parity bit
// (XOR of all data and parity bits) after p(R-1), giving N+1 output bits.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   in_bit    in   serial data bit, d0 first
//   in_valid  in   in_bit valid
//   in_ready  out  encoder accepts a bit this cycle
//   out_bit   out  serial codeword bit (registered)
//   out_valid out  out_bit valid (registered)
//   out_ready in   sink accepts out_bit
//   out_last  out  final codeword bit (registered)
//   busy      out  FSM not in IDLE
module hamming_serial_enc
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy
);

  localparam int K  = 2**R - 1 - R;
  localparam int N  = 2**R - 1;
`ifdef HAMMING_SECDED_EN
  localparam int PW   = R + 1;
  localparam int LAST = N;
`else
  localparam int PW   = R;
  localparam int LAST = N - 1;
`endif
  localparam int LEN = LAST + 1;
  localparam int CW  = $clog2(N + 2);

  if ((R < 3) || (R > MAX_R)) begin : g_bad_r
    $error("hamming_serial_enc: R must be in 3..6");
  end

  state_e          state_q;
  logic [K-1:0]    data_q, data_d;
  logic [PW-1:0]   par_q, par_d;
  logic [CW-1:0]   cnt_q, ocnt_q, ocnt_inc;
  logic            out_bit_q, out_valid_q, out_last_q;
  logic            accept;
  logic [R-1:0]    mask;
  logic [MAX_R-1:0] mask_full;
  logic [LEN-1:0]  cw;
  logic            nxt_bit;

  assign in_ready  = (state_q != EMIT);
  assign busy      = (state_q != IDLE);
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  assign accept   = in_valid & in_ready;
  assign ocnt_inc = ocnt_q + CW'(1);
  // Stream order is data LSB-first, then p0.., so the codeword is a concat.
  assign cw       = {par_q, data_q};

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mask_full = '0;
    mask      = '0;
    data_d    = data_q;
    par_d     = par_q;
    nxt_bit   = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (cnt_q == CW'(j)) begin
        mask_full = parity_mask(pos_of(j), R);
        if (accept) data_d[j] = in_bit;
      end
    end
    mask = mask_full[R-1:0];
    if (accept) begin
      par_d[R-1:0] = par_q[R-1:0] ^ (mask & {R{in_bit}});
`ifdef HAMMING_SECDED_EN
      // The bit reaches the overall parity once directly and once through
      // each parity it feeds; the net effect is odd only for an even mask.
      par_d[R] = par_q[R] ^ (in_bit & ~(^mask));
`endif
    end
    for (int i = 0; i < LEN; i++) begin
      if (ocnt_inc == CW'(i)) nxt_bit = cw[i];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data buffer is small and is cleared on reset so an aborted
      // frame can never leak stale bits into the next codeword.
      state_q     <= IDLE;
      data_q      <= '0;
      par_q       <= '0;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= data_d;
            par_q   <= par_d;
            cnt_q   <= CW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            data_q <= data_d;
            par_q  <= par_d;
            if (cnt_q == CW'(K - 1)) begin
              state_q     <= EMIT;
              cnt_q       <= '0;
              ocnt_q      <= '0;
              out_valid_q <= 1'b1;
              out_bit_q   <= data_d[0];
              out_last_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              ocnt_q      <= '0;
              par_q       <= '0;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              ocnt_q     <= ocnt_inc;
              out_bit_q  <= nxt_bit;
              out_last_q <= (ocnt_inc == CW'(LAST));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_enc.sv
// Self-checking bench for hamming_serial_enc: one R=4 and one R=3 instance,
// directed known-answer frames plus randomized frames with input gaps and
// output backpressure, compared against a position-based reference model.
// Honors HAMMING_SECDED_EN when defined.
module tb_hamming_serial_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_bit_v    = '0;
  logic [1:0] in_valid_v  = '0;
  logic [1:0] out_ready_v = 2'b11;
  logic [1:0] in_ready_v, out_bit_v, out_valid_v, out_last_v, busy_v;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAMMING_SECDED_EN
  localparam int SECDED = 1;
`else
  localparam int SECDED = 0;
`endif

  always #5 clk = ~clk;

  hamming_serial_enc #(.R(4)) u_r4 (
    .clk(clk), .rst(rst),
    .in_bit(in_bit_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .out_bit(out_bit_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_last(out_last_v[0]), .busy(busy_v[0])
  );

  hamming_serial_enc #(.R(3)) u_r3 (
    .clk(clk), .rst(rst),
    .in_bit(in_bit_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .out_bit(out_bit_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_last(out_last_v[1]), .busy(busy_v[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: place data at non-power-of-two positions, compute each
  // parity over positions with bit i set, then serialize in stream order.
  function automatic void model(input int r, input logic [63:0] d,
                                output logic [63:0] stream, output int len);
    int n, k, j;
    logic [63:0] posv;
    logic [7:0]  p;
    logic        overall;
    n = 2**r - 1;
    k = n - r;
    posv = '0;
    p = '0;
    j = 0;
    for (int pos = 1; pos <= n; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        posv[pos] = d[j];
        j++;
      end
    end
    for (int i = 0; i < r; i++)
      for (int pos = 1; pos <= n; pos++)
        if (((pos >> i) & 1) == 1) p[i] = p[i] ^ posv[pos];
    stream = '0;
    overall = 1'b0;
    for (int i = 0; i < k; i++) begin
      stream[i] = d[i];
      overall = overall ^ d[i];
    end
    for (int i = 0; i < r; i++) begin
      stream[k+i] = p[i];
      overall = overall ^ p[i];
    end
    len = n;
    if (SECDED != 0) begin
      stream[n] = overall;
      len = n + 1;
    end
  endfunction

  task automatic check_reset_values();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_out_valid%0d", s), 64'(out_valid_v[s]), 64'd0);
      check($sformatf("rst_out_bit%0d", s),   64'(out_bit_v[s]),   64'd0);
      check($sformatf("rst_out_last%0d", s),  64'(out_last_v[s]),  64'd0);
      check($sformatf("rst_busy%0d", s),      64'(busy_v[s]),      64'd0);
      check($sformatf("rst_in_ready%0d", s),  64'(in_ready_v[s]),  64'd1);
    end
  endtask

  // Called at a negedge with stimulus already set for the reset edge.
  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid_v = '0;
    out_ready_v = 2'b11;
    check_reset_values();
  endtask

  // smode: 0 = always ready, 1 = toggle every cycle, 2 = random.
  // abort_in / abort_out: reset once that many bits were accepted/emitted.
  task automatic run_frame(input int sel, input logic [63:0] d, input int gaps,
                           input int smode, input int abort_in, input int abort_out,
                           output logic [63:0] cap);
    int r, k, len, acc, idx, budget;
    logic [63:0] exp;
    logic stalled, prev_bit, prev_last, rdy;
    r = (sel == 1) ? 3 : 4;
    k = 2**r - 1 - r;
    model(r, d, exp, len);
    cap = '0;
    acc = 0;
    budget = 0;
    while (acc < k) begin
      @(negedge clk);
      if (abort_in != 0 && acc == abort_in) begin
        in_valid_v[sel] = 1'b1;
        in_bit_v[sel] = d[acc];
        pulse_reset();
        return;
      end
      check("in_ready_load", 64'(in_ready_v[sel]), 64'd1);
      check("no_early_valid", 64'(out_valid_v[sel]), 64'd0);
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        in_valid_v[sel] = 1'b0;
        in_bit_v[sel] = 1'($urandom_range(0, 1));
      end else begin
        in_valid_v[sel] = 1'b1;
        in_bit_v[sel] = d[acc];
        acc++;
      end
      budget++;
      if (budget > 1000) begin
        check("input_timeout", 64'(acc), 64'(k));
        return;
      end
    end
    @(negedge clk);
    in_valid_v[sel] = 1'b0;
    idx = 0;
    stalled = 1'b0;
    prev_bit = 1'b0;
    prev_last = 1'b0;
    rdy = 1'b0;
    budget = 0;
    while (idx < len) begin
      check("out_valid", 64'(out_valid_v[sel]), 64'd1);
      check("in_ready_emit", 64'(in_ready_v[sel]), 64'd0);
      check("busy_emit", 64'(busy_v[sel]), 64'd1);
      if (stalled) begin
        check("stall_bit", 64'(out_bit_v[sel]), 64'(prev_bit));
        check("stall_last", 64'(out_last_v[sel]), 64'(prev_last));
      end
      if (abort_out != 0 && idx == abort_out) begin
        out_ready_v[sel] = 1'b1;
        pulse_reset();
        return;
      end
      case (smode)
        0:       rdy = 1'b1;
        1:       rdy = (budget == 0) ? 1'b1 : ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready_v[sel] = rdy;
      if (rdy) begin
        cap[idx] = out_bit_v[sel];
        check($sformatf("bit%0d", idx), 64'(out_bit_v[sel]), 64'(exp[idx]));
        check($sformatf("last%0d", idx), 64'(out_last_v[sel]), 64'(idx == len - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev_bit = out_bit_v[sel];
        prev_last = out_last_v[sel];
      end
      @(negedge clk);
      budget++;
      if (budget > 1000) begin
        check("output_timeout", 64'(idx), 64'(len));
        return;
      end
    end
    out_ready_v[sel] = 1'b1;
    check("done_valid", 64'(out_valid_v[sel]), 64'd0);
    check("done_busy", 64'(busy_v[sel]), 64'd0);
    check("done_in_ready", 64'(in_ready_v[sel]), 64'd1);
    check("done_last", 64'(out_last_v[sel]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap, ref_cap, d;
    int sel, k;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values();

    // Known-answer frames
    run_frame(0, 64'h003, 0, 0, 0, 0, ref_cap);
    check("kat003_data", 64'(ref_cap[10:0]), 64'h003);
    check("kat003_par", 64'(ref_cap[14:11]), 64'b0110);
    run_frame(0, 64'h7FF, 0, 0, 0, 0, cap);
    check("kat7ff_par", 64'(cap[14:11]), 64'b1111);
    run_frame(0, 64'h000, 0, 0, 0, 0, cap);
    check("kat000_all", 64'(cap[14:0]), 64'd0);
    run_frame(1, 64'hB, 0, 0, 0, 0, cap);
    check("r3_data", 64'(cap[3:0]), 64'b1011);
    check("r3_par", 64'(cap[6:4]), 64'b001);
    if (SECDED != 0) begin
      run_frame(0, 64'h001, 0, 0, 0, 0, cap);
      check("sec001_par", 64'(cap[14:11]), 64'b0011);
      check("sec001_all", 64'(cap[15]), 64'd1);
      check("sec003_all", 64'(ref_cap[15]), 64'd0);
    end

    // Backpressure and input gaps must not change the stream
    run_frame(0, 64'h003, 1, 1, 0, 0, cap);
    check("stall_stream", cap, ref_cap);

    // Mid-frame resets, each followed by a clean frame
    run_frame(0, 64'h5A5, 0, 0, 5, 0, cap);
    repeat (3) @(negedge clk);
    check("no_valid_after_rst", 64'(out_valid_v[0]), 64'd0);
    run_frame(0, 64'h003, 0, 0, 0, 0, cap);
    check("post_rst_in", cap, ref_cap);
    run_frame(0, 64'h2C3, 0, 0, 0, 2, cap);
    check("no_valid_after_rst2", 64'(out_valid_v[0]), 64'd0);
    run_frame(0, 64'h003, 1, 2, 0, 0, cap);
    check("post_rst_out", cap, ref_cap);

    // Randomized frames on both widths
    for (int t = 0; t < 16; t++) begin
      sel = int'($urandom_range(0, 1));
      k = (sel == 1) ? 4 : 11;
      d = 64'($urandom) & ((64'd1 << k) - 64'd1);
      run_frame(sel, d, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0, 0, cap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_serial_enc.md
Name: hamming_serial_enc

Overview:
Parametrised serial Hamming encoder, the successor to the fixed (15,11) serial encoder core. It accepts K = 2^R-1-R data bits LSB-first over a valid/ready bit stream and buffers the full word. It then emits the N = 2^R-1 bit codeword serially: data bits LSB-first, then parity bits p0..p(R-1). The block sits between a serial message source and a serial line driver, and supports output backpressure and an optional SECDED overall-parity bit.

Parameters:
R, 4, number of Hamming parity bits; legal range 3..6 (elaboration-time assertion otherwise).
K, 2**R-1-R, derived data width (localparam, not overridable).
N, 2**R-1, derived codeword width before the optional extension bit (localparam).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
in_bit  in  1  serial data bit; data bit d0 first.
in_valid  in  1  in_bit is valid this cycle.
in_ready  out  1  encoder accepts a bit this cycle.
out_bit  out  1  serial codeword bit.
out_valid  out  1  out_bit is valid.
out_ready  in  1  sink accepts out_bit this cycle.
out_last  out  1  high with the final codeword bit.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Position map: codeword positions are 1..N, and parity p_i sits at position 2^i.
  - Data bits d0..d(K-1) occupy the non-power-of-two positions in ascending order.
  - p_i = XOR of all d_j whose position has bit i set.
- FSM states: IDLE, LOAD, EMIT.
- Reset: state=IDLE; in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0; counters, parity register and data buffer all cleared.
- IDLE: in_ready=1. An accepted bit (in_valid&in_ready) is stored as d0 and the FSM moves to LOAD with cnt=1.
- LOAD: in_ready=1. Each accepted bit is stored at d[cnt], and the parity register is updated on the fly by XOR of the bit into every p_i selected by its position.
  - Gaps in in_valid are allowed; cnt holds.
  - The accept with cnt==K-1 moves the FSM to EMIT with ocnt=0.
- EMIT: in_ready=0 and out_valid=1.
  - out_bit = d[ocnt] for ocnt<K, otherwise p[ocnt-K].
  - ocnt advances only on out_valid&out_ready.
  - out_bit and out_last hold stable while out_ready=0.
  - out_last=1 when ocnt==LAST (N-1, or N with SECDED_EN).
  - A transfer with out_last returns the FSM to IDLE. in_ready rises the next cycle; there is no input/output overlap.
- Latency: the first output bit is valid the cycle after the K-th input accept. With out_ready held high, a full frame takes K input cycles plus N (or N+1) output cycles.
- out_bit, out_valid and out_last are registered outputs. in_ready is decoded from state.
- Reset mid-operation (LOAD or EMIT): the frame is discarded and the block returns to the reset values on the next edge. A partial word is never emitted.
- Counter widths: $clog2(N+2). Parity register is R bits (R+1 with SECDED_EN).

Optional Feature:
HAMMING_SECDED_EN
- Defined:
  - Adds overall parity bit pN = XOR of all data and parity bits, emitted after p(R-1).
  - The codeword becomes N+1 bits and out_last moves to that bit.
- Undefined: the codeword is exactly N bits and no extension logic exists.

Decomposition:
- Package hamming_pkg:
  - State enum typedef (IDLE/LOAD/EMIT).
  - Function pos_of(j) giving the codeword position of data bit j.
  - Function parity_mask(pos, R) returning the R-bit set of parity indices the position feeds.
- Sub-module: none needed. Parity accumulation is a small XOR loop inside the core; a separate module would be a thin wrapper.

Test Plan:
- R=4, send d=11'b00000000011 with out_ready=1 -> stream d0..d10, then parity p3..p0=4'b0110; out_last on bit 15; busy low afterwards.
- R=4, d=11'h7FF -> parity p3..p0=4'b1111; d=11'h000 -> all 15 bits 0.
- R=3, d=4'b1011 -> out sequence 1,1,0,1, then p0..p2 = 1,0,0; out_last on bit 7.
- R=4, d=11'h003, out_ready toggled 1/0 every cycle, in_valid with random gaps -> identical 15-bit stream, out_bit stable while stalled, in_ready=0 throughout EMIT.
- Assert rst for 1 cycle at the 6th input bit, then at the 3rd output bit -> outputs return to reset values next cycle, no out_valid until a new full 11-bit word is sent; the following frame encodes correctly.
- HAMMING_SECDED_EN, R=4: d=11'h001 -> parity 4'b0011 plus overall bit 1 (16 bits); d=11'h003 -> overall bit 0.
